ac_match_collector: RTL and testbench
=====================================

# ac_match_collector

- Downstream stage of the Aho-Corasick matcher (`TOP`). Consumes the per-character match vector the automaton produces and tags each vector with the stream position of the character that completed the match.
- Buffers tagged vectors in a small FIFO, then serialises them into one (pattern ID, position) report per valid/ready handshake.
- Lets a slow host drain bursts of simultaneous matches without stalling the character stream.

## Interface

Parameters:
- `PAT_N`, default 4: number of patterns (match vector width); must be ≥ 2.
- `POS_W`, default 8: width of the stream position counter.
- `DEPTH`, default 8: FIFO entries; must be a power of 2.

Ports:
- `CLK` input 1: sole clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `EN` input 1: a character was consumed by the matcher this cycle; `MATCH` is valid when high.
- `CLR` input 1: synchronous clear of FIFO, position counter and `OVERFLOW`.
- `MATCH` input `PAT_N`: per-pattern match flags for the current character.
- `OUT_VALID` output 1: a report is presented.
- `OUT_READY` input 1: host accepts the report.
- `OUT_PAT` output `$clog2(PAT_N)`: pattern index of the report.
- `OUT_POS` output `POS_W`: position of the character that completed the match.
- `OVERFLOW` output 1: sticky; a nonzero match vector was dropped.
- `LEVEL` output `$clog2(DEPTH)+1`: FIFO occupancy in entries.
- `MATCH_TOTAL` output 16: reported-match count; see Configuration.

## Operation

- **Position counter `pos`:**
  - Reset value 0.
  - On every cycle with `EN`=1 it increments by 1 modulo 2^`POS_W`, wrapping silently.
  - The value captured with a match is the pre-increment `pos`. The first character of the stream is position 0.
- **Push:** happens when `EN`=1 and `MATCH`≠0. A FIFO entry is written as {mask=`MATCH`, pos}. A vector with `MATCH`=0, or with `EN`=0, is never stored.
- **Head serialisation:**
  - `OUT_VALID` = FIFO non-empty.
  - `OUT_PAT` = index of the lowest set bit of the head's pending mask.
  - `OUT_POS` = head pos.
  - On each `OUT_VALID`&`OUT_READY` the reported bit is cleared from the pending mask.
  - When the final bit is cleared, the entry is popped in the same cycle.
  - Patterns sharing one position are therefore reported in ascending index order, one per cycle.
- **Full:**
  - A push while `LEVEL`=`DEPTH` is accepted only if the head pops in that same cycle.
  - Otherwise the vector is dropped, the FIFO is unchanged, and `OVERFLOW` sets. `pos` still increments.
- **Simultaneous push and pop:** both take effect and `LEVEL` is unchanged.
- **`OVERFLOW`:** cleared only by `RST` or `CLR`.
- **`CLR`:**
  - Empties the FIFO, discards any partial head mask, zeroes `pos`, and clears `OVERFLOW`.
  - It has priority over push and pop in the same cycle.
  - A handshake in the `CLR` cycle is not counted.
- **Reset values:** `OUT_VALID`=0, `OUT_PAT`=0, `OUT_POS`=0, `OVERFLOW`=0, `LEVEL`=0, `MATCH_TOTAL`=0, `pos`=0, all pointers 0.
- **Reset mid-operation:** asynchronous assertion immediately forces all of the above. Pending reports are lost.

## Timing

- `MATCH` sampled at edge N appears at the outputs after edge N, so `OUT_VALID` is high in cycle N+1 when the FIFO was empty. Latency is 1 cycle.
- Throughput is one report per cycle while `OUT_READY`=1.
- An entry with k set bits occupies the head for k handshake cycles.
- `OUT_PAT` and `OUT_POS` are stable while `OUT_VALID`=1 and `OUT_READY`=0, except under `CLR` or `RST`.
- All outputs are registered or decoded from registered state only. There is no combinational path from `OUT_READY` or `MATCH` to any output.

## Configuration

- `AC_MATCH_TOTAL_EN` defined:
  - `MATCH_TOTAL` counts completed handshakes.
  - It saturates at 16'hFFFF.
  - It is cleared by `RST` and `CLR`.
- Undefined: `MATCH_TOTAL` is tied to 0 and no counter logic is built.

## Test plan

1. **Single match, idle host.** Reset, then `EN`=1 for 5 characters with `MATCH`=4'b0000,0000,0010,0000,0000 and `OUT_READY`=1.
   -> Exactly one report, `OUT_PAT`=1, `OUT_POS`=2, one cycle after the match. `MATCH_TOTAL`=1 (macro on).
2. **Multi-pattern vector.** `MATCH`=4'b1011 at position 0, `OUT_READY`=1.
   -> Three consecutive reports (0,0), (1,0), (3,0). `LEVEL` goes 1→1→1→0.
3. **Overflow.** `OUT_READY`=0, `DEPTH`=8, 9 consecutive characters each with `MATCH`=4'b0001.
   -> `LEVEL`=8, `OVERFLOW`=1 after the 9th. Draining yields positions 0..7 only.
4. **Full with simultaneous pop.** FIFO full of single-bit entries, `OUT_READY`=1, `MATCH`=4'b0100 on the pop cycle.
   -> The push is accepted, `LEVEL` stays 8, `OVERFLOW` stays 0. The last report drained is pattern 2.
5. **Position wrap.** `POS_W`=4, match on the 17th character.
   -> `OUT_POS`=0.
6. **Clear and async reset.** `CLR` pulse while 3 entries are pending and `OVERFLOW`=1.
   -> Next cycle `LEVEL`=0, `OUT_VALID`=0, `OVERFLOW`=0, and the next match reports pos 0.
   Repeat the setup with `RST` asserted mid-cycle: the outputs clear before the next edge.

Source files
------------

// File: rtl/ac_match_collector.sv
// ac_match_collector: tags Aho-Corasick match vectors with stream position, buffers them, serialises one (pattern, position) report per handshake.
// Optional macro AC_MATCH_TOTAL_EN builds a saturating count of completed handshakes on MATCH_TOTAL.
module ac_match_collector #(
    parameter int PAT_N = 4,
    parameter int POS_W = 8,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       EN,
    input  logic                       CLR,
    input  logic [PAT_N-1:0]           MATCH,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [$clog2(PAT_N)-1:0]   OUT_PAT,
    output logic [POS_W-1:0]           OUT_POS,
    output logic                       OVERFLOW,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic [15:0]                MATCH_TOTAL
);
    localparam int PW = $clog2(PAT_N);
    localparam int AW = $clog2(DEPTH);
    logic [PAT_N-1:0] mask_mem [DEPTH];
    logic [POS_W-1:0] pos_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [POS_W-1:0] pos;
    logic [PAT_N-1:0] head_mask, head_rest;
    logic [PW-1:0]    low_idx;
    logic             hs, pop, push_req, push, full;

    assign head_mask = mask_mem[rd_ptr];
    assign head_rest = head_mask & (head_mask - PAT_N'(1));
    always_comb begin
        low_idx = '0;
        for (int i = PAT_N - 1; i >= 0; i--)
            if (head_mask[i]) low_idx = PW'(i);
    end

    assign OUT_VALID = count != '0;
    assign OUT_PAT   = OUT_VALID ? low_idx : '0;
    assign OUT_POS   = OUT_VALID ? pos_mem[rd_ptr] : '0;
    assign LEVEL     = count;
    assign hs        = OUT_VALID & OUT_READY;
    assign pop       = hs & (head_rest == '0);
    assign push_req  = EN & (|MATCH);
    assign full      = count == (AW+1)'(DEPTH);
    // When full, rd_ptr == wr_ptr: the push write below overrides the head update.
    assign push      = push_req & (!full | pop);

    always_ff @(posedge CLK) begin
        if (hs) mask_mem[rd_ptr] <= head_rest;
        if (push) begin
            mask_mem[wr_ptr] <= MATCH;
            pos_mem[wr_ptr]  <= pos;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pos      <= '0;
            OVERFLOW <= 1'b0;
        end else if (CLR) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pos      <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (EN) pos <= pos + POS_W'(1);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push_req && !push) OVERFLOW <= 1'b1;
        end
    end

`ifdef AC_MATCH_TOTAL_EN
    logic [15:0] total;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) total <= '0;
        else if (CLR) total <= '0;
        else if (hs && total != 16'hFFFF) total <= total + 16'd1;
    end
    assign MATCH_TOTAL = total;
`else
    assign MATCH_TOTAL = '0;
`endif
endmodule

// File: tb/tb_ac_match_collector.sv
// tb_ac_match_collector: directed vectors with hand-computed expectations for ac_match_collector.
module tb_ac_match_collector;
    logic        CLK = 1'b0;
    logic        RST, EN, CLR, OUT_READY;
    logic [3:0]  MATCH;
    logic        OUT_VALID, OVERFLOW;
    logic [1:0]  OUT_PAT;
    logic [7:0]  OUT_POS;
    logic [3:0]  LEVEL;
    logic [15:0] MATCH_TOTAL;
    int checks = 0;
    int errors = 0;
    int reps;

    ac_match_collector #(.PAT_N(4), .POS_W(8), .DEPTH(8)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .MATCH(MATCH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PAT(OUT_PAT),
        .OUT_POS(OUT_POS), .OVERFLOW(OVERFLOW), .LEVEL(LEVEL),
        .MATCH_TOTAL(MATCH_TOTAL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_total(input string tag, input int n);
`ifdef AC_MATCH_TOTAL_EN
        chk(tag, 32'(MATCH_TOTAL), n);
`else
        chk(tag, 32'(MATCH_TOTAL), 0);
`endif
    endtask

    task automatic clear;
        EN = 1'b0;
        OUT_READY = 1'b0;
        CLR = 1'b1;
        tick;
        CLR = 1'b0;
    endtask

    initial begin
        logic [3:0] t1 [5] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        RST = 1'b1; EN = 1'b0; CLR = 1'b0; OUT_READY = 1'b0; MATCH = '0;
        tick;
        tick;
        chk("rst_valid", 32'(OUT_VALID), 0);
        chk("rst_pat", 32'(OUT_PAT), 0);
        chk("rst_pos", 32'(OUT_POS), 0);
        chk("rst_ovf", 32'(OVERFLOW), 0);
        chk("rst_level", 32'(LEVEL), 0);
        chk_total("rst_total", 0);
        RST = 1'b0;

        // single match
        OUT_READY = 1'b1; EN = 1'b1; reps = 0;
        for (int i = 0; i < 5; i++) begin
            MATCH = t1[i];
            tick;
            chk($sformatf("t1_valid%0d", i), 32'(OUT_VALID), (i == 2) ? 1 : 0);
            if (OUT_VALID) begin
                reps++;
                chk("t1_pat", 32'(OUT_PAT), 1);
                chk("t1_pos", 32'(OUT_POS), 2);
            end
        end
        EN = 1'b0;
        tick;
        chk("t1_reps", reps, 1);
        chk_total("t1_total", 1);

        // multi-pattern vector
        clear;
        chk_total("clr_total", 0);
        OUT_READY = 1'b1; EN = 1'b1; MATCH = 4'b1011;
        tick;
        EN = 1'b0;
        chk("t2_pat0", 32'(OUT_PAT), 0); chk("t2_pos0", 32'(OUT_POS), 0); chk("t2_lvl0", 32'(LEVEL), 1);
        tick;
        chk("t2_pat1", 32'(OUT_PAT), 1); chk("t2_pos1", 32'(OUT_POS), 0); chk("t2_lvl1", 32'(LEVEL), 1);
        tick;
        chk("t2_pat2", 32'(OUT_PAT), 3); chk("t2_pos2", 32'(OUT_POS), 0); chk("t2_lvl2", 32'(LEVEL), 1);
        tick;
        chk("t2_valid", 32'(OUT_VALID), 0); chk("t2_lvl3", 32'(LEVEL), 0);
        chk_total("t2_total", 3);

        // overflow
        clear;
        EN = 1'b1; MATCH = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            tick;
            chk($sformatf("t3_ovf%0d", i), 32'(OVERFLOW), (i == 8) ? 1 : 0);
        end
        chk("t3_level", 32'(LEVEL), 8);
        EN = 1'b0; OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_pat%0d", i), 32'(OUT_PAT), 0);
            chk($sformatf("t3_pos%0d", i), 32'(OUT_POS), i);
            tick;
        end
        chk("t3_empty", 32'(OUT_VALID), 0);
        chk("t3_ovf_sticky", 32'(OVERFLOW), 1);
        chk_total("t3_total", 8);

        // full with simultaneous pop
        clear;
        EN = 1'b1; MATCH = 4'b0001;
        repeat (8) tick;
        chk("t4_full", 32'(LEVEL), 8);
        OUT_READY = 1'b1; MATCH = 4'b0100;
        tick;
        EN = 1'b0;
        chk("t4_level", 32'(LEVEL), 8);
        chk("t4_ovf", 32'(OVERFLOW), 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_pat%0d", i), 32'(OUT_PAT), (i == 7) ? 2 : 0);
            chk($sformatf("t4_pos%0d", i), 32'(OUT_POS), i + 1);
            tick;
        end
        chk("t4_empty", 32'(LEVEL), 0);
        chk_total("t4_total", 9);

        // position wrap
        clear;
        OUT_READY = 1'b1; EN = 1'b1; MATCH = 4'b0000;
        repeat (255) tick;
        chk("t5_idle", 32'(OUT_VALID), 0);
        MATCH = 4'b0001;
        tick;
        chk("t5_pat255", 32'(OUT_PAT), 0); chk("t5_pos255", 32'(OUT_POS), 255);
        MATCH = 4'b0010;
        tick;
        EN = 1'b0;
        chk("t5_pat_wrap", 32'(OUT_PAT), 1); chk("t5_pos_wrap", 32'(OUT_POS), 0);
        chk("t5_level", 32'(LEVEL), 1);
        tick;
        chk("t5_empty", 32'(OUT_VALID), 0);
        chk_total("t5_total", 2);

        // clear with pending entries and overflow
        clear;
        EN = 1'b1; MATCH = 4'b0001;
        repeat (9) tick;
        EN = 1'b0; OUT_READY = 1'b1;
        repeat (5) tick;
        chk("t6_level3", 32'(LEVEL), 3);
        chk("t6_ovf1", 32'(OVERFLOW), 1);
        CLR = 1'b1; EN = 1'b1; MATCH = 4'b0001;
        tick;
        CLR = 1'b0; EN = 1'b0; OUT_READY = 1'b0;
        chk("t6_clr_level", 32'(LEVEL), 0);
        chk("t6_clr_valid", 32'(OUT_VALID), 0);
        chk("t6_clr_ovf", 32'(OVERFLOW), 0);
        chk_total("t6_clr_total", 0);
        EN = 1'b1; MATCH = 4'b1000;
        tick;
        EN = 1'b0;
        chk("t6_pat", 32'(OUT_PAT), 3);
        chk("t6_pos", 32'(OUT_POS), 0);

        // async reset mid-cycle
        EN = 1'b1; MATCH = 4'b0001;
        repeat (9) tick;
        EN = 1'b0;
        chk("t7_level8", 32'(LEVEL), 8);
        chk("t7_ovf1", 32'(OVERFLOW), 1);
        #2 RST = 1'b1;
        #1;
        chk("t7_valid", 32'(OUT_VALID), 0);
        chk("t7_level", 32'(LEVEL), 0);
        chk("t7_ovf", 32'(OVERFLOW), 0);
        chk("t7_pat", 32'(OUT_PAT), 0);
        chk("t7_pos", 32'(OUT_POS), 0);
        chk_total("t7_total", 0);
        tick;
        RST = 1'b0;
        EN = 1'b1; MATCH = 4'b0100;
        tick;
        EN = 1'b0;
        chk("t7_post_pat", 32'(OUT_PAT), 2);
        chk("t7_post_pos", 32'(OUT_POS), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
